// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN input path: writer FSM states and the
// default widths/depths common to the sub input FIFO and its fill engine.
package cnn_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int INPUT_COL_WIDTH = 6;
  localparam int INPUT_ROW_WIDTH = 6;
  localparam int FIFO_DEPTH      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Walks a row_length x num_rows tile one word per accepted request, producing
// the current read address and a flag marking the final word of the tile.
module tile_addr_gen #(
  parameter int INPUT_COL_WIDTH = 6,
  parameter int INPUT_ROW_WIDTH = 6,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic                       i_advance,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [INPUT_COL_WIDTH-1:0] i_row_length,
  input  logic [INPUT_ROW_WIDTH-1:0] i_num_rows,
  input  logic [ADDR_WIDTH-1:0]      i_row_stride,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_last_word
);

  logic [INPUT_COL_WIDTH-1:0] col_q, col_d;
  logic [INPUT_ROW_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0]      row_base_q, row_base_d;
  logic [INPUT_COL_WIDTH-1:0] row_len_q, row_len_d;
  logic [INPUT_ROW_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [ADDR_WIDTH-1:0]      stride_q, stride_d;
  logic                       row_end;

  assign row_end     = (col_q == row_len_q - INPUT_COL_WIDTH'(1));
  assign o_last_word = row_end && (row_q == num_rows_q - INPUT_ROW_WIDTH'(1));
  assign o_addr      = row_base_q + ADDR_WIDTH'(col_q);

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    stride_d   = stride_q;
    if (i_load) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = i_base_addr;
      row_len_d  = i_row_length;
      num_rows_d = i_num_rows;
      stride_d   = i_row_stride;
    end else if (i_advance) begin
      if (row_end) begin
        col_d      = '0;
        row_d      = row_q + INPUT_ROW_WIDTH'(1);
        row_base_d = row_base_q + stride_q;
      end else begin
        col_d = col_q + INPUT_COL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  // Tile geometry is only consulted after a load, so it carries no reset.
  always_ff @(posedge i_clock) begin
    row_len_q  <= row_len_d;
    num_rows_q <= num_rows_d;
    stride_q   <= stride_d;
  end

endmodule

// File: rtl/sub_input_fifo_writer.sv
// Fill engine for one sub input FIFO: fetches a tile from the feature buffer and
// writes each returned word into the FIFO, throttled by FIFO occupancy credit.
module sub_input_fifo_writer #(
  parameter int DATA_WIDTH      = cnn_pkg::DATA_WIDTH,
  parameter int INPUT_COL_WIDTH = cnn_pkg::INPUT_COL_WIDTH,
  parameter int INPUT_ROW_WIDTH = cnn_pkg::INPUT_ROW_WIDTH,
  parameter int ADDR_WIDTH      = 16,
  parameter int FIFO_DEPTH      = cnn_pkg::FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int POINTER_WIDTH   = $clog2(FIFO_DEPTH)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [INPUT_COL_WIDTH-1:0] i_row_length,
  input  logic [INPUT_ROW_WIDTH-1:0] i_num_rows,
  input  logic [ADDR_WIDTH-1:0]      i_row_stride,
  output logic                       o_mem_req,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic                       i_mem_ready,
  input  logic                       i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]      i_mem_rdata,
  input  logic [POINTER_WIDTH:0]     i_fifo_element_count,
  output logic                       o_wenable,
  output logic [DATA_WIDTH-1:0]      o_wdata,
  output logic                       o_busy,
  output logic                       o_done
);
  import cnn_pkg::*;

  localparam int IFW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CSW = POINTER_WIDTH + 2;

  writer_state_t         state_q, state_d;
  logic [IFW-1:0]        in_flight_q, in_flight_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic           load, accept, rsp, last_word, credit_ok, slot_ok;
  logic [CSW-1:0] credit_sum;

  assign load = (state_q == IDLE) && i_start;

  tile_addr_gen #(
    .INPUT_COL_WIDTH (INPUT_COL_WIDTH),
    .INPUT_ROW_WIDTH (INPUT_ROW_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_addr_gen (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (load),
    .i_advance    (accept),
    .i_base_addr  (i_base_addr),
    .i_row_length (i_row_length),
    .i_num_rows   (i_num_rows),
    .i_row_stride (i_row_stride),
    .o_addr       (o_mem_addr),
    .o_last_word  (last_word)
  );

  // Words already in the FIFO, on their way back, or being written this cycle
  // all consume FIFO space; a new read is allowed only if one slot remains.
  assign credit_sum = CSW'(i_fifo_element_count) + CSW'(in_flight_q) + CSW'(wen_q);
  assign credit_ok  = credit_sum < CSW'(FIFO_DEPTH);
  assign slot_ok    = in_flight_q < IFW'(MAX_OUTSTANDING);

  assign o_mem_req = (state_q == ISSUE) && credit_ok && slot_ok;
  assign accept    = o_mem_req && i_mem_ready;
  assign rsp       = i_mem_rvalid && (in_flight_q != '0);

  always_comb begin
    in_flight_d = in_flight_q;
    case ({accept, rsp})
      2'b10:   in_flight_d = in_flight_q + IFW'(1);
      2'b01:   in_flight_d = in_flight_q - IFW'(1);
      default: in_flight_d = in_flight_q;
    endcase
    wen_d   = rsp;
    wdata_d = rsp ? i_mem_rdata : wdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if ((i_row_length == '0) || (i_num_rows == '0)) state_d = DONE;
          else                                           state_d = ISSUE;
        end
      end
      ISSUE: if (accept && last_word) state_d = DRAIN;
      // Leave once nothing is outstanding and no write is queued for next
      // cycle, so o_done lands one cycle after the final write.
      DRAIN: if ((in_flight_q == '0) && !wen_d) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      in_flight_q <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_wenable = wen_q;
  assign o_wdata   = wdata_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_sub_input_fifo_writer.sv
// Bench for sub_input_fifo_writer: in-order feature buffer model with
// configurable latency/ready pattern and address/write-data scoreboards.
`timescale 1ns/1ps
module tb_sub_input_fifo_writer;
  localparam int DW = 32, CW = 6, RW = 6, AW = 16, FD = 32, MO = 4, PW = 5;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_mem_ready, i_mem_rvalid;
  logic [AW-1:0] i_base_addr, i_row_stride;
  logic [CW-1:0] i_row_length;
  logic [RW-1:0] i_num_rows;
  logic [DW-1:0] i_mem_rdata;
  logic [PW:0]   i_fifo_element_count;
  logic          o_mem_req, o_wenable, o_busy, o_done;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_wdata;

  sub_input_fifo_writer #(
    .DATA_WIDTH(DW), .INPUT_COL_WIDTH(CW), .INPUT_ROW_WIDTH(RW), .ADDR_WIDTH(AW),
    .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_row_length(i_row_length), .i_num_rows(i_num_rows), .i_row_stride(i_row_stride),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ready(i_mem_ready),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .i_fifo_element_count(i_fifo_element_count), .o_wenable(o_wenable), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int due; logic [AW-1:0] addr; } rsp_t;

  int checks = 0, errors = 0, cyc = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  rsp_t          mem_q[$];
  int mem_lat = 2, ready_mode = 0, accept_budget = 0, bench_inflight = 0;
  int last_wen_cyc = -100, wen_count = 0, req_count = 0, rvalid_count = 0;
  int peak_inflight = 0, peak_occ = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Feature buffer model plus continuous write/request monitors.
  task automatic bus_model();
    rsp_t r;
    logic rv, acc, consume;
    logic [AW-1:0] ra;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (o_wenable) begin
        wen_count++;
        last_wen_cyc = cyc;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got wdata=%h, required no write", o_wdata);
        end else begin
          d = exp_data_q.pop_front();
          if (o_wdata !== d) begin
            errors++;
            $display("FAIL write_data: got %h, expected %h", o_wdata, d);
          end
        end
      end
      case (ready_mode)
        0:       i_mem_ready = 1'b1;
        1:       i_mem_ready = (cyc % 2 == 0);
        2:       i_mem_ready = (accept_budget > 0);
        default: i_mem_ready = 1'b0;
      endcase
      rv = 1'b0;
      ra = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r  = mem_q.pop_front();
        rv = 1'b1;
        ra = r.addr;
        rvalid_count++;
      end
      i_mem_rvalid = rv;
      i_mem_rdata  = rv ? mem_data(ra) : 32'hBAD0_BAD0;
      #4;
      acc = o_mem_req && i_mem_ready;
      if (bench_inflight > peak_inflight) peak_inflight = bench_inflight;
      if (bench_inflight + int'(o_wenable) > peak_occ) peak_occ = bench_inflight + int'(o_wenable);
      if (o_mem_req) begin
        req_count++;
        checks++;
        if (!(bench_inflight < MO &&
              int'(i_fifo_element_count) + bench_inflight + int'(o_wenable) < FD)) begin
          errors++;
          $display("FAIL credit: req with inflight=%0d count=%0d wen=%0d, required no req",
                   bench_inflight, i_fifo_element_count, o_wenable);
        end
        if (prev_stall) begin
          checks++;
          if (o_mem_addr !== prev_addr) begin
            errors++;
            $display("FAIL addr_hold: got %h, expected %h", o_mem_addr, prev_addr);
          end
        end
      end
      prev_stall = o_mem_req && !i_mem_ready;
      prev_addr  = o_mem_addr;
      if (acc) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_request: got addr %h, required no request", o_mem_addr);
        end else begin
          ra = exp_addr_q.pop_front();
          if (o_mem_addr !== ra) begin
            errors++;
            $display("FAIL req_addr: got %h, expected %h", o_mem_addr, ra);
          end
        end
        r.due  = cyc + mem_lat;
        r.addr = o_mem_addr;
        mem_q.push_back(r);
        if (ready_mode == 2) accept_budget--;
      end
      consume = rv && (bench_inflight > 0);
      if (consume) exp_data_q.push_back(i_mem_rdata);
      bench_inflight = bench_inflight + (acc ? 1 : 0) - (consume ? 1 : 0);
      if (!i_reset) begin
        bench_inflight = 0;
        exp_data_q.delete();
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic start_tile(input logic [AW-1:0] base, input int len, input int rows,
                            input logic [AW-1:0] stride, output int n);
    logic [AW-1:0] a;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < len; c++) begin
        a = base + AW'(r) * stride + AW'(c);
        exp_addr_q.push_back(a);
      end
    @(negedge clk);
    i_base_addr  = base;
    i_row_length = CW'(len);
    i_num_rows   = RW'(rows);
    i_row_stride = stride;
    i_start      = 1'b1;
    n            = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (o_done) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({o_mem_req, o_wenable, o_busy, o_done} !== 4'b0 || o_mem_addr !== '0 || o_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h wen=%b wdata=%h busy=%b done=%b, expected all 0",
               o_mem_req, o_mem_addr, o_wenable, o_wdata, o_busy, o_done);
    end
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b req=%b, expected 0 0", o_busy, o_mem_req);
    end
  endtask

  task automatic test_basic_tile();
    int n, at, w0;
    bit ok;
    mem_lat = 2; ready_mode = 0; i_fifo_element_count = '0;
    w0 = wen_count;
    start_tile(16'h0100, 4, 3, 16'h0010, n);
    #1;
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL start_latency: got req=%b addr=%h at N+1, expected 1 0100", o_mem_req, o_mem_addr);
    end
    wait_done(200, at, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done, expected done"); end
    checks++;
    if (at != last_wen_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: got cycle %0d, expected %0d", at, last_wen_cyc + 1);
    end
    checks++;
    if (wen_count - w0 != 12 || exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL basic_count: got %0d writes (%0d addr, %0d data left), expected 12 0 0",
               wen_count - w0, exp_addr_q.size(), exp_data_q.size());
    end
    @(negedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b done=%b, expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_fifo_credit();
    int n, at, w0;
    bit ok;
    mem_lat = 2; ready_mode = 0;
    w0 = wen_count;
    i_fifo_element_count = 6'd30;
    peak_inflight = 0; peak_occ = 0;
    start_tile(16'h0200, 8, 2, 16'h0040, n);
    repeat (20) @(negedge clk);
    checks++;
    if (peak_inflight != 2 || peak_occ != 2) begin
      errors++;
      $display("FAIL credit_peak: got inflight=%0d occ=%0d, expected 2 2", peak_inflight, peak_occ);
    end
    i_fifo_element_count = 6'd32;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL credit_stall: got req=%b busy=%b, expected 0 1", o_mem_req, o_busy);
      end
    end
    @(negedge clk);
    i_fifo_element_count = 6'd28;
    #1;
    checks++;
    if (o_mem_req !== 1'b1) begin
      errors++;
      $display("FAIL credit_resume: got req=%b, expected 1", o_mem_req);
    end
    wait_done(300, at, ok);
    checks++;
    if (!ok || wen_count - w0 != 16 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL credit_tile: got done=%b writes=%0d addr_left=%0d, expected 1 16 0",
               ok, wen_count - w0, exp_addr_q.size());
    end
    i_fifo_element_count = '0;
  endtask

  task automatic test_backpressure();
    int n, at, w0;
    bit ok;
    mem_lat = 10; ready_mode = 1; i_fifo_element_count = '0;
    w0 = wen_count;
    peak_inflight = 0;
    start_tile(16'h0300, 5, 3, 16'h0100, n);
    wait_done(400, at, ok);
    checks++;
    if (!ok || wen_count - w0 != 15 || exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_tile: got done=%b writes=%0d addr_left=%0d, expected 1 15 0",
               ok, wen_count - w0, exp_addr_q.size());
    end
    checks++;
    if (peak_inflight != MO) begin
      errors++;
      $display("FAIL max_outstanding: got peak %0d, expected %0d", peak_inflight, MO);
    end
    checks++;
    if (at != last_wen_cyc + 1) begin
      errors++;
      $display("FAIL backpressure_done_timing: got %0d, expected %0d", at, last_wen_cyc + 1);
    end
  endtask

  task automatic test_addr_wrap();
    int n, at, w0;
    bit ok;
    mem_lat = 2; ready_mode = 0;
    w0 = wen_count;
    start_tile(16'hFFFE, 4, 1, 16'h0000, n);
    wait_done(100, at, ok);
    checks++;
    if (!ok || wen_count - w0 != 4 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_tile: got done=%b writes=%0d addr_left=%0d, expected 1 4 0",
               ok, wen_count - w0, exp_addr_q.size());
    end
  endtask

  task automatic test_zero_size();
    int n, w0, r0;
    w0 = wen_count; r0 = req_count;
    start_tile(16'h0700, 3, 0, 16'h0010, n);
    #1;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || cyc != n + 1) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b at %0d, expected 1 1 at %0d", o_done, o_busy, cyc, n + 1);
    end
    i_row_length = 6'd2; i_num_rows = 6'd2; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got done=%b busy=%b, expected 0 0", o_done, o_busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (req_count != r0 || wen_count != w0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_activity: got %0d reqs %0d writes busy=%b, expected 0 0 0",
               req_count - r0, wen_count - w0, o_busy);
    end
  endtask

  task automatic test_reset_mid_tile();
    int n, at, w0, rv0, t;
    bit ok;
    mem_lat = 8; ready_mode = 2; accept_budget = 3; i_fifo_element_count = '0;
    start_tile(16'h0400, 8, 2, 16'h0020, n);
    t = 0;
    while (bench_inflight != 3 && t < 20) begin @(negedge clk); #1; t++; end
    checks++;
    if (bench_inflight != 3) begin
      errors++;
      $display("FAIL mid_setup: got inflight %0d, expected 3", bench_inflight);
    end
    @(negedge clk);
    i_reset = 1'b0;
    rv0 = rvalid_count;
    w0  = wen_count;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_mem_req, o_wenable, o_busy, o_done} !== 4'b0 || o_mem_addr !== '0 || o_wdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got req=%b addr=%h wen=%b wdata=%h busy=%b done=%b, expected all 0",
               o_mem_req, o_mem_addr, o_wenable, o_wdata, o_busy, o_done);
    end
    i_reset = 1'b1;
    exp_addr_q.delete();
    t = 0;
    while (mem_q.size() != 0 && t < 40) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid_count - rv0 != 3 || wen_count != w0) begin
      errors++;
      $display("FAIL late_rvalid: got %0d rvalids %0d writes, expected 3 0", rvalid_count - rv0, wen_count - w0);
    end
    mem_lat = 2; ready_mode = 0;
    w0 = wen_count;
    start_tile(16'h0500, 3, 2, 16'h0008, n);
    wait_done(100, at, ok);
    checks++;
    if (!ok || wen_count - w0 != 6 || exp_addr_q.size() != 0 || at != last_wen_cyc + 1) begin
      errors++;
      $display("FAIL post_reset_tile: got done=%b writes=%0d addr_left=%0d, expected 1 6 0",
               ok, wen_count - w0, exp_addr_q.size());
    end
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0; i_fifo_element_count = '0; i_base_addr = '0;
    i_row_length = '0; i_num_rows = '0; i_row_stride = '0;
    fork bus_model(); join_none
    test_reset();
    test_basic_tile();
    test_fifo_credit();
    test_backpressure();
    test_addr_wrap();
    test_zero_size();
    test_reset_mid_tile();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_input_fifo_writer.md
# sub_input_fifo_writer

Fill engine on the write side of one sub input FIFO. It fetches a rectangular tile of input feature-map words from the on-chip feature buffer, row by row. It then pushes each word into the FIFO through that FIFO's `wenable`/`wdata` port. Issue is credit-throttled against the FIFO's element count so that no write is ever dropped on a full FIFO. One instance sits between the feature buffer arbiter and each sub input FIFO.

## Interface
- `DATA_WIDTH`, 32, word width; must equal the FIFO data width.
- `INPUT_COL_WIDTH`, 6, width of the row-length field.
- `INPUT_ROW_WIDTH`, 6, width of the row-count field.
- `ADDR_WIDTH`, 16, feature buffer word-address width.
- `FIFO_DEPTH`, 32, depth of the attached FIFO.
- `MAX_OUTSTANDING`, 4, maximum number of accepted but unreturned reads.
- `POINTER_WIDTH`, `$clog2(FIFO_DEPTH)`; the element-count input is `POINTER_WIDTH+1` bits wide.

Ports:
- `i_clock`  in  1  clock; the block has one clock domain.
- `i_reset`  in  1  reset, synchronous and active-low.
- `i_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `i_base_addr`  in  ADDR_WIDTH  address of the first word of the tile.
- `i_row_length`  in  INPUT_COL_WIDTH  number of words per row.
- `i_num_rows`  in  INPUT_ROW_WIDTH  number of rows in the tile.
- `i_row_stride`  in  ADDR_WIDTH  address step from the start of one row to the start of the next.
- `o_mem_req`  out  1  read request to the feature buffer.
- `o_mem_addr`  out  ADDR_WIDTH  read address.
- `i_mem_ready`  in  1  buffer accepts the request; a read is accepted when `o_mem_req && i_mem_ready`.
- `i_mem_rvalid`  in  1  read data valid; responses return in order.
- `i_mem_rdata`  in  DATA_WIDTH  read data.
- `i_fifo_element_count`  in  POINTER_WIDTH+1  current occupancy of the FIFO.
- `o_wenable`  out  1  FIFO write enable.
- `o_wdata`  out  DATA_WIDTH  FIFO write data.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at tile completion.

## Operation
**FSM states:** IDLE, ISSUE, DRAIN, DONE.

**IDLE**
- On `i_start`, latch the configuration.
- If `i_row_length==0` or `i_num_rows==0`, go to DONE.
- Otherwise go to ISSUE, with the column counter = 0, the row counter = 0, and `row_base = i_base_addr`.

**ISSUE**
- `o_mem_addr = row_base + col`, computed modulo 2^ADDR_WIDTH.
- `o_mem_req = (in_flight < MAX_OUTSTANDING) && (i_fifo_element_count + in_flight + o_wenable < FIFO_DEPTH)`.
  - The sum is computed at `POINTER_WIDTH+2` bits so it cannot overflow.
- On each accepted request, `col` increments.
- At `col == row_length-1`, `col` returns to 0, `row_base += i_row_stride` (with wrap-around), and the row counter increments.
- Acceptance of the last word (last column of the last row) moves the FSM to DRAIN.

**DRAIN**
- No further requests are issued.
- Go to DONE when `in_flight == 0` and `o_wenable == 0`.

**DONE**
- `o_done = 1` for this one cycle, then go to IDLE.

**Credit and data path**
- `in_flight` increments on request accept and decrements on `i_mem_rvalid`.
- When both happen in the same cycle, the count is unchanged.
- `i_mem_rvalid` with `in_flight == 0` is ignored: no write and no count change.
- Each `i_mem_rvalid` is registered into `o_wenable` and `o_wdata` on the next edge.

**Other rules**
- `i_start` while `o_busy` is ignored.
- Reset mid-tile:
  - All state is discarded.
  - Responses still returning from the buffer are not written once the block is in IDLE.
  - This is possible because `in_flight` is 0 after reset, so those responses fall under the ignore rule above.

## Timing
- **Reset values:** `o_mem_req=0`, `o_mem_addr=0`, `o_wenable=0`, `o_wdata=0`, `o_busy=0`, `o_done=0`, `in_flight=0`, state = IDLE.
- **Start latency:** `i_start` at cycle N gives the first `o_mem_req` at cycle N+1, provided credit is available.
- **Data latency:** `i_mem_rvalid` at cycle N gives `o_wenable` at cycle N+1, with data unchanged.
- **Issue rate:** up to 1 request per cycle. Throughput is limited only by `i_mem_ready`, the outstanding limit and the FIFO credit.
- **Request hold:** while `o_mem_req=1` and `i_mem_ready=0`, `o_mem_addr` holds its value.
  - `o_mem_req` may drop if credit disappears; it stays low until credit returns.
- **FIFO safety:** `o_wenable` is never asserted while the FIFO is full. This is guaranteed by the credit rule.
- **`o_done` timing:** `o_done` asserts exactly one cycle after the last `o_wenable`, or at N+1 for an empty tile.

## Structure
- **Shared package** (`cnn_pkg`): state enum `writer_state_t` {IDLE, ISSUE, DRAIN, DONE}.
  - Default parameter constants are shared with the sub input FIFO: `DATA_WIDTH`, `INPUT_COL_WIDTH`, `FIFO_DEPTH`.
- **Sub-module:** one natural sub-module, `tile_addr_gen`. It holds the column counter, row counter and `row_base`, and produces `o_mem_addr` and `last_word`.
- **Top level:** the FSM, the credit counter and the write register stay in the top level.

## Test plan
- **Basic tile:** base 0x0100, length 4, rows 3, stride 0x0010, `i_mem_ready=1`, rvalid 2 cycles after accept.
  - Requested addresses: 0x100–0x103, 0x110–0x113, 0x120–0x123.
  - 12 writes in order.
  - `o_done` one cycle after the 12th write.
- **FIFO credit:** hold `i_fifo_element_count=30` with FIFO_DEPTH 32.
  - At most 2 requests are outstanding plus pending writes.
  - `o_mem_req` drops and resumes when the count falls to 28.
- **Backpressure:** toggle `i_mem_ready` 0/1 every cycle.
  - `o_mem_addr` is stable while stalled.
  - No address is skipped or duplicated.
  - `in_flight` never exceeds 4.
- **Address wrap:** base 0xFFFE, length 4, rows 1.
  - Addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Zero size:** `i_num_rows=0` with start.
  - No `o_mem_req`, no `o_wenable`.
  - `o_done` at N+1.
  - A second `i_start` during busy is ignored.
- **Reset mid-tile:** drive `i_reset` low during ISSUE with 3 reads in flight; the 3 responses then arrive after reset is released.
  - All outputs are 0.
  - The late rvalids produce no `o_wenable`.
  - A new tile runs correctly afterwards.
